// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [15:0] EXC_HI_DEF   = 16'hBFC0;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_exc_pc(input logic [31:0] pc, input logic [15:0] exc_hi);
    return (pc[31:16] == exc_hi);
  endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Wishbone classic read port between the fetch stage and the program memories.
interface mips_fetch_if #(
  parameter int unsigned WADDR = 13
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [3:0]       sel;
  logic [WADDR-1:0] adr;
  logic             exc;
  logic [31:0]      dat;
  logic             ack;
  logic             err;

  modport master (output cyc, stb, we, sel, adr, exc, input dat, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, exc, output dat, ack, err);
endinterface

// File: rtl/mips_fetch_fifo.sv
// Two-entry instruction buffer; entry 0 is the head and drives the decode outputs.
module mips_fetch_fifo
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok_s;
  logic         push_ok_s;

  // Next-state for entries and occupancy; flush beats push and pop.
  always_comb begin
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    count_d   = count_q;
    pop_ok_s  = pop_i & (count_q != 2'd0);
    push_ok_s = push_i & ((count_q != 2'd2) | pop_ok_s);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d = din_i;
          end else begin
            ent1_d = din_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = din_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = din_i;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = ent0_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch stage: sequential PC generation, one-at-a-time Wishbone reads,
// two-entry buffering towards decode and redirect/flush handling.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter int unsigned WADDR    = 13,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [15:0] EXC_HI   = EXC_HI_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic [31:0]        instr_pc_o,
  output logic               instr_err_o,
  mips_fetch_if.master       wb
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             stop_q, stop_d;
  logic             cyc_q, cyc_d;
  logic [WADDR-1:0] adr_q, adr_d;
  logic             exc_q, exc_d;

  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic             bus_done_s;
  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_s;
  logic             full_s;
  logic             empty_s;

  // FSM next-state, PC update, bus request and FIFO push.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    stop_d             = stop_q;
    cyc_d              = cyc_q;
    adr_d              = adr_q;
    exc_d              = exc_q;
    push_s             = 1'b0;
    push_entry_s.err   = 1'b0;
    push_entry_s.pc    = pc_q;
    push_entry_s.instr = NOP;
    bus_done_s         = wb.ack | wb.err;
    flush_s            = redirect_i;
    pop_s              = instr_ready_i & ~empty_s;

    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          pc_d   = redirect_pc_i;
          stop_d = 1'b0;
        end else if (!stop_q && !full_s) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            adr_d   = pc_q[WADDR+1:2];
            exc_d   = is_exc_pc(pc_q, EXC_HI);
          end else begin
            // Misaligned target: report it once and wait for a redirect.
            push_s           = 1'b1;
            push_entry_s.err = 1'b1;
            stop_d           = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_done_s) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          if (redirect_i) begin
            pc_d   = redirect_pc_i;
            stop_d = 1'b0;
          end else begin
            push_s             = 1'b1;
            push_entry_s.err   = wb.err;
            push_entry_s.instr = wb.err ? NOP : wb.dat;
            pc_d               = pc_q + 32'd4;
            stop_d             = wb.err;
          end
        end else if (redirect_i) begin
          state_d = ST_DRAIN;
          pc_d    = redirect_pc_i;
          stop_d  = 1'b0;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_DRAIN: begin
        if (redirect_i) begin
          pc_d   = redirect_pc_i;
          stop_d = 1'b0;
        end else begin
          pc_d = pc_q;
        end
        if (bus_done_s) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State, PC and bus-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      stop_q  <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stop_q  <= stop_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      exc_q   <= exc_d;
    end
  end

  mips_fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (push_entry_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign instr_valid_o = ~empty_s;
  assign instr_o       = head_s.instr;
  assign instr_pc_o    = head_s.pc;
  assign instr_err_o   = head_s.err;

  assign wb.cyc = cyc_q;
  assign wb.stb = cyc_q;
  assign wb.we  = 1'b0;
  assign wb.sel = 4'hF;
  assign wb.adr = adr_q;
  assign wb.exc = exc_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch with a Wishbone memory model of programmable latency.
module tb_mips_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;

  int          lat = 1;
  int          cnt = 0;
  logic        err_en = 1'b0;
  logic [12:0] err_adr = 13'h0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mips_fetch_if #(.WADDR(13)) wb ();

  mips_fetch #(.WADDR(13)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_err_o   (instr_err),
    .wb            (wb)
  );

  // Memory contents: region tag in the top half, word address in the bottom bits.
  assign wb.dat = {(wb.exc ? 16'hE000 : 16'hA000), 3'b000, wb.adr};

  // Registered ack/err after lat cycles of cyc; abandoned cycles are tolerated.
  always @(posedge clk) begin
    if (rst) begin
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      cnt    <= 0;
    end else if (wb.ack || wb.err) begin
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      cnt    <= 0;
    end else if (wb.cyc && wb.stb) begin
      if (cnt + 1 >= lat) begin
        if (err_en && wb.adr == err_adr) wb.err <= 1'b1;
        else                             wb.ack <= 1'b1;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] epc,
                             input logic [31:0] ein, input logic eerr);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, epc);
    chk({tag, "_instr"}, instr, ein);
    chk({tag, "_err"}, {31'd0, instr_err}, {31'd0, eerr});
  endtask

  initial begin
    int n;
    int seen;

    // Reset state
    tick(3);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cyc", {31'd0, wb.cyc}, 32'd0);
    chk("rst_stb", {31'd0, wb.stb}, 32'd0);
    chk("rst_adr", {19'd0, wb.adr}, 32'd0);
    chk("rst_exc", {31'd0, wb.exc}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_err", {31'd0, instr_err}, 32'd0);
    chk("we", {31'd0, wb.we}, 32'd0);
    chk("sel", {28'd0, wb.sel}, 32'h0000_000F);

    // 1: sequential fetch, first word within 3 clocks
    rst   = 1'b0;
    ready = 1'b1;
    tick(1);
    chk("t1_cyc", {31'd0, wb.cyc}, 32'd1);
    chk("t1_adr", {19'd0, wb.adr}, 32'd0);
    tick(2);
    chk("t1_first_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_first_pc", instr_pc, 32'h0000_0000);
    chk("t1_first_instr", instr, 32'hA000_0000);
    expect_word("t1_w4", 32'h0000_0004, 32'hA000_0001, 1'b0);
    expect_word("t1_w8", 32'h0000_0008, 32'hA000_0002, 1'b0);

    // 2: back-pressure fills exactly two entries and holds the head
    ready = 1'b0;
    tick(10);
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_held_pc", instr_pc, 32'h0000_0008);
    chk("t2_held_instr", instr, 32'hA000_0002);
    chk("t2_cyc_idle", {31'd0, wb.cyc}, 32'd0);
    ready = 1'b1;
    expect_word("t2_w12", 32'h0000_000C, 32'hA000_0003, 1'b0);
    expect_word("t2_w16", 32'h0000_0010, 32'hA000_0004, 1'b0);

    // 3: redirect into exception memory while a slow cycle is outstanding
    lat = 3;
    tick(1);
    chk("t3_cyc", {31'd0, wb.cyc}, 32'd1);
    chk("t3_adr", {19'd0, wb.adr}, 32'h0000_0005);
    do_redirect(32'hBFC0_0180);
    chk("t3_drain_cyc", {31'd0, wb.cyc}, 32'd1);
    chk("t3_drain_valid", {31'd0, instr_valid}, 32'd0);
    n = 0;
    while (wb.cyc && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t3_drain_done", {31'd0, wb.cyc}, 32'd0);
    chk("t3_stale_dropped", {31'd0, instr_valid}, 32'd0);
    tick(1);
    chk("t3_new_cyc", {31'd0, wb.cyc}, 32'd1);
    chk("t3_new_adr", {19'd0, wb.adr}, 32'h0000_0060);
    chk("t3_new_exc", {31'd0, wb.exc}, 32'd1);
    lat = 1;
    expect_word("t3_exc_word", 32'hBFC0_0180, 32'hE000_0060, 1'b0);

    // 4: misaligned redirect flushes the buffer and yields one error entry
    ready = 1'b0;
    do_redirect(32'h0000_0102);
    chk("t4_flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_no_cyc", {31'd0, wb.cyc}, 32'd0);
    tick(1);
    chk("t4_valid", {31'd0, instr_valid}, 32'd1);
    chk("t4_err", {31'd0, instr_err}, 32'd1);
    chk("t4_pc", instr_pc, 32'h0000_0102);
    chk("t4_instr", instr, 32'd0);
    ready = 1'b1;
    seen  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb.cyc) seen++;
    end
    chk("t4_stopped_cyc", seen, 32'd0);
    chk("t4_stopped_valid", {31'd0, instr_valid}, 32'd0);
    do_redirect(32'h0000_0100);
    expect_word("t4_resume", 32'h0000_0100, 32'hA000_0040, 1'b0);

    // 5: bus error at 0x40 stops issuing until the next redirect
    err_en  = 1'b1;
    err_adr = 13'h0010;
    do_redirect(32'h0000_0040);
    expect_word("t5_buserr", 32'h0000_0040, 32'h0000_0000, 1'b1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb.cyc) seen++;
    end
    chk("t5_stopped_cyc", seen, 32'd0);
    err_en = 1'b0;
    do_redirect(32'h0000_0200);
    expect_word("t5_resume", 32'h0000_0200, 32'hA000_0080, 1'b0);

    // 6: reset during an outstanding cycle
    lat = 3;
    tick(1);
    chk("t6_cyc_before", {31'd0, wb.cyc}, 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t6_cyc", {31'd0, wb.cyc}, 32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_adr", {19'd0, wb.adr}, 32'd0);
    rst = 1'b0;
    lat = 1;
    tick(1);
    chk("t6_refetch_cyc", {31'd0, wb.cyc}, 32'd1);
    chk("t6_refetch_adr", {19'd0, wb.adr}, 32'd0);
    expect_word("t6_word0", 32'h0000_0000, 32'hA000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
